// File: rtl/stream_window_gen.sv
// Streaming K x K window generator: K-1 line buffers feed a K x K shift window, and
// every STRIDE-aligned valid-padding position is emitted with its frame coordinates.
module stream_window_gen #(
  parameter int WORD_SIZE   = 8,
  parameter int CHANNELS    = 1,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 10,
  parameter int IMG_HEIGHT  = 10,
  parameter int STRIDE      = 1,
  localparam int PW = WORD_SIZE * CHANNELS,
  localparam int K  = KERNEL_SIZE,
  localparam int RW = $clog2(IMG_HEIGHT),
  localparam int CW = $clog2(IMG_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PW-1:0]                   in_pixel,
  input  logic                            in_sof,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [K-1:0][K-1:0][PW-1:0]     win_out,
  output logic [RW-1:0]                   win_row,
  output logic [CW-1:0]                   win_col,
  output logic                            win_last,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int PHW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [PHW-1:0] PH_LAST  = PHW'(STRIDE - 1);
  localparam logic [RW-1:0]  ROW_K1   = RW'(K - 1);
  localparam logic [CW-1:0]  COL_K1   = CW'(K - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_WIDTH - 1);
  // Bottom-right coordinates of the final stride-aligned window of a frame.
  localparam logic [RW-1:0]  ROW_WIN_LAST = RW'(K - 1 + ((IMG_HEIGHT - K) / STRIDE) * STRIDE);
  localparam logic [CW-1:0]  COL_WIN_LAST = CW'(K - 1 + ((IMG_WIDTH - K) / STRIDE) * STRIDE);

  logic [RW-1:0]  row_reg, row_eff, row_next;
  logic [CW-1:0]  col_reg, col_eff, col_next;
  logic [PHW-1:0] rph_reg, rph_eff, rph_next;
  logic [PHW-1:0] cph_reg, cph_eff, cph_next;
  logic           accept, emit;
  logic [K-1:0][PW-1:0]   col_vec;
  logic [K-1:0][PW-1:0]   win_reg [K];
  logic                   out_valid_reg, win_last_reg;
  logic [RW-1:0]          win_row_reg;
  logic [CW-1:0]          win_col_reg;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel is forced to (0,0) with both stride phases cleared.
  assign row_eff = in_sof ? '0 : row_reg;
  assign col_eff = in_sof ? '0 : col_reg;
  assign rph_eff = in_sof ? '0 : rph_reg;
  assign cph_eff = in_sof ? '0 : cph_reg;

  assign emit = accept && (row_eff >= ROW_K1) && (col_eff >= COL_K1)
                && (rph_eff == '0) && (cph_eff == '0);

  // Phases only start counting once the position reaches K-1 in that axis.
  always_comb begin
    col_next = col_eff + CW'(1);
    cph_next = (cph_eff == PH_LAST) ? '0 : cph_eff + PHW'(1);
    row_next = row_eff;
    rph_next = rph_eff;
    if (col_eff < COL_K1) begin
      cph_next = '0;
    end
    if (col_eff == COL_LAST) begin
      col_next = '0;
      cph_next = '0;
      row_next = row_eff + RW'(1);
      rph_next = (rph_eff == PH_LAST) ? '0 : rph_eff + PHW'(1);
      if (row_eff < ROW_K1) begin
        rph_next = '0;
      end
      if (row_eff == ROW_LAST) begin
        row_next = '0;
        rph_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg <= '0;
      col_reg <= '0;
      rph_reg <= '0;
      cph_reg <= '0;
    end else if (accept) begin
      row_reg <= row_next;
      col_reg <= col_next;
      rph_reg <= rph_next;
      cph_reg <= cph_next;
    end
  end

  assign col_vec[K-1] = in_pixel;

  genvar gi;
  generate
    // Line buffer gi holds frame row (r-K+1+gi) at each column; data shifts up one row per accept.
    for (gi = 0; gi < K - 1; gi++) begin : g_line
      logic [PW-1:0] mem [IMG_WIDTH];
      assign col_vec[gi] = mem[col_eff];
      always_ff @(posedge clk) begin
        if (accept) begin
          mem[col_eff] <= col_vec[gi+1];
        end
      end
    end

    for (gi = 0; gi < K; gi++) begin : g_win
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          win_reg[gi] <= '0;
        end else if (accept) begin
          win_reg[gi] <= {col_vec[gi], win_reg[gi][K-1:1]};
        end
      end
      assign win_out[gi] = win_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      win_row_reg   <= '0;
      win_col_reg   <= '0;
      win_last_reg  <= 1'b0;
    end else if (emit) begin
      out_valid_reg <= 1'b1;
      win_row_reg   <= row_eff - ROW_K1;
      win_col_reg   <= col_eff - COL_K1;
      win_last_reg  <= (row_eff == ROW_WIN_LAST) && (col_eff == COL_WIN_LAST);
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign win_row   = win_row_reg;
  assign win_col   = win_col_reg;
  assign win_last  = win_last_reg;

endmodule

// File: tb/tb_stream_window_gen.sv
// Randomised scoreboard bench: dut_a (1 channel, stride 1) and dut_b (3 channels, stride 2)
// are driven in turn; expected windows come from a raster model of each frame.
`timescale 1ns/1ps
module tb_stream_window_gen;
  localparam int K = 3;
  localparam int W = 10;
  localparam int H = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_sof, in_valid, out_ready;
  logic [23:0] in_pixel;
  int          sel, ready_mode, gap_mode, stride;
  logic [23:0] pmask;

  logic in_valid_a, in_ready_a, out_valid_a, win_last_a;
  logic [3:0] win_row_a, win_col_a;
  logic [K-1:0][K-1:0][7:0] win_out_a;
  logic in_valid_b, in_ready_b, out_valid_b, win_last_b;
  logic [3:0] win_row_b, win_col_b;
  logic [K-1:0][K-1:0][23:0] win_out_b;

  assign in_valid_a = in_valid && (sel == 0);
  assign in_valid_b = in_valid && (sel == 1);

  stream_window_gen #(.WORD_SIZE(8), .CHANNELS(1), .KERNEL_SIZE(K), .IMG_WIDTH(W),
                      .IMG_HEIGHT(H), .STRIDE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_pixel(in_pixel[7:0]), .in_sof(in_sof),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .win_out(win_out_a),
    .win_row(win_row_a), .win_col(win_col_a), .win_last(win_last_a),
    .out_valid(out_valid_a), .out_ready(out_ready));

  stream_window_gen #(.WORD_SIZE(8), .CHANNELS(3), .KERNEL_SIZE(K), .IMG_WIDTH(W),
                      .IMG_HEIGHT(H), .STRIDE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_pixel(in_pixel), .in_sof(in_sof),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .win_out(win_out_b),
    .win_row(win_row_b), .win_col(win_col_b), .win_last(win_last_b),
    .out_valid(out_valid_b), .out_ready(out_ready));

  logic cur_in_ready, cur_out_valid, cur_last;
  logic [3:0] cur_row, cur_col;
  logic [K-1:0][K-1:0][23:0] cur_win;

  always_comb begin
    cur_win       = '0;
    cur_in_ready  = (sel == 0) ? in_ready_a  : in_ready_b;
    cur_out_valid = (sel == 0) ? out_valid_a : out_valid_b;
    cur_last      = (sel == 0) ? win_last_a  : win_last_b;
    cur_row       = (sel == 0) ? win_row_a   : win_row_b;
    cur_col       = (sel == 0) ? win_col_a   : win_col_b;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        cur_win[i][j] = (sel == 0) ? {16'h0, win_out_a[i][j]} : win_out_b[i][j];
  end

  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
    logic       last;
    logic [K-1:0][K-1:0][23:0] win;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] frame [H][W];
  int          checks = 0, errors = 0, win_seen = 0, exp_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_br(input int r, input int c);
    return (r >= K - 1) && (c >= K - 1) && ((r - (K - 1)) % stride == 0)
           && ((c - (K - 1)) % stride == 0);
  endfunction

  task automatic build(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       frame[r][c] = 24'(10 * r + c);
          1:       frame[r][c] = {8'(r), 8'(c), 8'(r ^ c)};
          default: frame[r][c] = 24'($urandom);
        endcase
  endtask

  // Every stride-aligned window whose bottom-right pixel lies among the first n pixels.
  task automatic push_expected(input int n);
    exp_t e;
    int   maxal;
    maxal = ((H - K) / stride) * stride;
    exp_n = 0;
    for (int idx = 0; idx < n; idx++) begin
      int r, c, tr, tc;
      r = idx / W;
      c = idx % W;
      if (is_br(r, c)) begin
        tr = r - (K - 1);
        tc = c - (K - 1);
        e.row  = 4'(tr);
        e.col  = 4'(tc);
        e.last = (n == W * H) && (tr == maxal) && (tc == maxal);
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            e.win[i][j] = frame[tr + i][tc + j] & pmask;
        exp_q.push_back(e);
        exp_n++;
      end
    end
  endtask

  task automatic send(input int n, input bit sof_first);
    for (int idx = 0; idx < n; idx++) begin
      int r, c;
      bit acc;
      r = idx / W;
      c = idx % W;
      if (gap_mode != 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      in_pixel = frame[r][c];
      in_sof   = sof_first && (idx == 0);
      in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge clk);
        acc = cur_in_ready;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: pixel %0d never accepted", idx);
        break;
      end
      if (is_br(r, c)) check("latency_out_valid", 64'(cur_out_valid), 64'd1);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() > 0; t++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("win_count", 64'(win_seen), 64'(exp_n));
  endtask

  task automatic run_frame(input int kind, input int n, input bit sof, input bit do_drain);
    build(kind);
    win_seen = 0;
    push_expected(n);
    send(n, sof);
    if (do_drain) drain();
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops one expectation per output handshake and checks stalled outputs hold.
  initial begin
    exp_t e;
    bit   held = 1'b0;
    logic [K-1:0][K-1:0][23:0] h_win;
    logic [9:0] h_meta;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          checks++;
          if (cur_out_valid !== 1'b1 || cur_win !== h_win || {cur_row, cur_col, cur_last, 1'b0} !== h_meta) begin
            errors++;
            $display("FAIL hold: got v=%0b row=%0d col=%0d win=%h required row=%0d col=%0d win=%h",
                     cur_out_valid, cur_row, cur_col, cur_win, h_meta[9:6], h_meta[5:2], h_win);
          end
        end
        held   = cur_out_valid && !out_ready;
        h_win  = cur_win;
        h_meta = {cur_row, cur_col, cur_last, 1'b0};
        if (cur_out_valid && out_ready) begin
          win_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_window: row=%0d col=%0d last=%0b", cur_row, cur_col, cur_last);
          end else begin
            e = exp_q.pop_front();
            if (cur_win !== e.win || cur_row !== e.row || cur_col !== e.col || cur_last !== e.last) begin
              errors++;
              $display("FAIL window: got row=%0d col=%0d last=%0b win=%h required row=%0d col=%0d last=%0b win=%h",
                       cur_row, cur_col, cur_last, cur_win, e.row, e.col, e.last, e.win);
            end else begin
              $display("dut%0d window row=%0d col=%0d last=%0b ok", sel, cur_row, cur_col, cur_last);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    sel = 0; ready_mode = 0; gap_mode = 0; stride = 1; pmask = 24'h0000ff;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid_a", 64'(out_valid_a), 64'd0);
    check("rst_out_valid_b", 64'(out_valid_b), 64'd0);
    check("rst_in_ready_a", 64'(in_ready_a), 64'd1);
    check("rst_meta_a", 64'({win_row_a, win_col_a, win_last_a}), 64'd0);
    check("rst_meta_b", 64'({win_row_b, win_col_b, win_last_b}), 64'd0);
    check("rst_win_a", 64'(win_out_a), 64'd0);
    check("rst_win_b", 64'(|win_out_b), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Stride 1: full-rate frame, toggled out_ready, sof truncation, random stalls.
    run_frame(0, W * H, 1'b0, 1'b1);
    ready_mode = 1;
    run_frame(0, W * H, 1'b1, 1'b1);
    ready_mode = 2; gap_mode = 1;
    run_frame(2, 45, 1'b1, 1'b1);
    run_frame(0, W * H, 1'b1, 1'b1);

    // Reset while a window is pending, then a fresh frame.
    ready_mode = 0; gap_mode = 0;
    run_frame(0, 46, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(cur_out_valid), 64'd0);
    check("midrst_in_ready", 64'(cur_in_ready), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(0, W * H, 1'b0, 1'b1);

    // Stride 2 with three packed channels.
    sel = 1; stride = 2; pmask = 24'hffffff;
    run_frame(0, W * H, 1'b1, 1'b1);
    ready_mode = 2; gap_mode = 1;
    run_frame(1, W * H, 1'b1, 1'b1);
    ready_mode = 1;
    run_frame(2, 57, 1'b1, 1'b1);
    run_frame(2, W * H, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
